// File: rtl/midi_pkg.sv
// Shared constants, serializer state type and byte-class helpers for the MIDI transmit path.
package midi_pkg;

   localparam logic [7:0] MIDI_CH_STATUS_MIN = 8'h80;
   localparam logic [7:0] MIDI_CH_STATUS_MAX = 8'hEF;
   localparam logic [7:0] MIDI_SYSCOM_MAX    = 8'hF7;
   localparam int         MIDI_BAUD          = 31250;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   function automatic logic is_ch_status(input logic [7:0] b);
      return (b >= MIDI_CH_STATUS_MIN) && (b <= MIDI_CH_STATUS_MAX);
   endfunction

   // System common / SysEx bytes cancel any running status held by the receiver.
   function automatic logic is_sys_common(input logic [7:0] b);
      return (b > MIDI_CH_STATUS_MAX) && (b <= MIDI_SYSCOM_MAX);
   endfunction

endpackage

// File: rtl/midi_uart_tx_if.sv
// Byte-queue and serial-line signals of the MIDI transmitter; master drives bytes, slave is the UART.
interface midi_uart_tx_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    tx_data;
   logic          tx_write;
   logic          running_status_en;
   logic          tx_full;
   logic          tx_idle;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic          txd;

   modport master (
      output tx_data, tx_write, running_status_en,
      input  tx_full, tx_idle, fifo_level, overflow, txd
   );

   modport slave (
      input  tx_data, tx_write, running_status_en,
      output tx_full, tx_idle, fifo_level, overflow, txd
   );
endinterface

// File: rtl/sync_byte_fifo.sv
// Byte FIFO with synchronous reset; DEPTH must be a power of two so pointers wrap naturally.
module sync_byte_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_write,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic          w_wr;
   logic          w_rd;

   // Full is judged on the registered level, so a same-cycle pop never admits a write.
   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rptr];
   assign w_wr    = i_write && !o_full;
   assign w_rd    = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end
endmodule

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 transmitter: FIFO-buffered bytes, optional running-status suppression, registered true-polarity txd.
module midi_uart_tx
   import midi_pkg::*;
#(
   parameter int CLK_RATE   = 50000000,
   parameter int BAUD       = MIDI_BAUD,
   parameter int FIFO_DEPTH = 16
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   midi_uart_tx_if.slave  bus
);
   localparam int BIT_CYC = CLK_RATE / BAUD;
   localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int LW      = $clog2(FIFO_DEPTH) + 1;

   tx_state_t     r_state;
   tx_state_t     w_state_nxt;
   logic [CW-1:0] r_baud;
   logic [CW-1:0] w_baud_nxt;
   logic [2:0]    r_bit;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    r_last;
   logic [7:0]    w_last_nxt;
   logic          r_txd;
   logic          r_ovf;
   logic          w_pop;
   logic          w_bit_end;
   logic [7:0]    w_fifo_data;
   logic          w_full;
   logic          w_empty;
   logic [LW-1:0] w_level;

   sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_write (bus.tx_write),
      .i_data  (bus.tx_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_bit_end      = (r_baud == CW'(BIT_CYC - 1));
   assign bus.tx_full    = w_full;
   assign bus.tx_idle    = w_empty && (r_state == ST_IDLE);
   assign bus.fifo_level = w_level;
   assign bus.overflow   = r_ovf;
   assign bus.txd        = r_txd;

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_last_nxt  = r_last;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_START;
            if (is_ch_status(r_shift)) begin
               if (bus.running_status_en && (r_shift == r_last)) w_state_nxt = ST_IDLE;
               else w_last_nxt = r_shift;
            end else if (is_sys_common(r_shift)) begin
               w_last_nxt = '0;
            end
         end
         ST_START: begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + CW'(1);
            if (w_bit_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + CW'(1);
            if (w_bit_end) begin
               w_bit_nxt = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + CW'(1);
            if (w_bit_end) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_last  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // txd follows the current state one cycle later, giving the 2-cycle mark gap between frames.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_txd <= 1'b1;
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf | (bus.tx_write & w_full);
         case (r_state)
            ST_START: r_txd <= 1'b0;
            ST_DATA:  r_txd <= r_shift[r_bit];
            default:  r_txd <= 1'b1;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_pop) r_shift <= w_fifo_data;
   end
endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: a line receiver decodes txd and is compared with a byte-stream model of running status.
module tb_midi_uart_tx;
   localparam int B     = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   midi_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   midi_uart_tx #(.CLK_RATE(B * 31250), .BAUD(31250), .FIFO_DEPTH(DEPTH)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] m_last = 8'h00;
   logic [7:0] stim[$];

   // Line receiver: mid-bit sampling relative to the first low sample.
   logic       rx_busy = 1'b0;
   int         rx_cnt  = 0;
   int         rx_ferr = 0;
   logic [7:0] rx_sh;
   always @(posedge clk) begin
      if (reset) begin
         rx_busy <= 1'b0;
         rx_cnt  <= 0;
      end else if (!rx_busy) begin
         if (bus.txd === 1'b0) begin
            rx_busy <= 1'b1;
            rx_cnt  <= 1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt == B / 2 && bus.txd !== 1'b0) begin
            rx_ferr <= rx_ferr + 1;
            rx_busy <= 1'b0;
         end
         for (int k = 0; k < 8; k++)
            if (rx_cnt == (k + 1) * B + B / 2) rx_sh[k] <= bus.txd;
         if (rx_cnt == 9 * B + B / 2) begin
            if (bus.txd !== 1'b1) rx_ferr <= rx_ferr + 1;
            else rx_q.push_back(rx_sh);
            rx_busy <= 1'b0;
         end
      end
   end

   // What a MIDI receiver should see for each queued byte.
   function automatic void model_push(input logic [7:0] b);
      if (b >= 8'h80 && b <= 8'hEF) begin
         if (bus.running_status_en && b == m_last) return;
         m_last = b;
      end else if (b >= 8'hF0 && b <= 8'hF7) begin
         m_last = 8'h00;
      end
      exp_q.push_back(b);
   endfunction

   function automatic logic [7:0] rnd_byte();
      logic [7:0] sys [4];
      sys = '{8'hF0, 8'hF7, 8'hF8, 8'hFE};
      case ($urandom_range(0, 3))
         0:       return 8'h90 | 8'($urandom_range(0, 1));
         1:       return 8'($urandom_range(0, 127));
         2:       return sys[$urandom_range(0, 3)];
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.tx_write = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd",   bus.txd, 1);
      chk("rst_full",  bus.tx_full, 0);
      chk("rst_idle",  bus.tx_idle, 1);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_ovf",   bus.overflow, 0);
      reset = 1'b0;
      rx_q.delete();
      exp_q.delete();
      m_last = 8'h00;
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int gap_max);
      foreach (s[i]) begin
         @(negedge clk);
         bus.tx_data  = s[i];
         bus.tx_write = 1'b1;
         model_push(s[i]);
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(0, gap_max);
            repeat (g) begin
               @(negedge clk);
               bus.tx_write = 1'b0;
            end
         end
      end
      @(negedge clk);
      bus.tx_write = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.tx_idle !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, bus.tx_idle, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic cmp_frames(input string tag, input int lit);
      chk({tag, "_n"}, rx_q.size(), exp_q.size());
      if (lit >= 0) chk({tag, "_cnt"}, rx_q.size(), lit);
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      int lows;
      bus.tx_data = 8'h00;
      bus.tx_write = 1'b0;
      bus.running_status_en = 1'b0;

      // Single byte 0x90: latency and bit-by-bit line check
      do_reset();
      d = 8'h90;
      @(negedge clk);
      bus.tx_data = d;
      bus.tx_write = 1'b1;
      model_push(d);
      @(negedge clk);
      bus.tx_write = 1'b0;
      chk("lat_lvl_n", bus.fifo_level, 1);
      chk("lat_txd_n", bus.txd, 1);
      @(negedge clk);
      chk("lat_lvl_n1", bus.fifo_level, 0);
      chk("lat_idle_n1", bus.tx_idle, 0);
      chk("lat_txd_n1", bus.txd, 1);
      @(negedge clk);
      chk("lat_txd_n2", bus.txd, 1);
      @(negedge clk);
      chk("lat_txd_n3", bus.txd, 0);
      repeat (B / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         repeat (B) @(negedge clk);
         chk($sformatf("bit%0d", k), bus.txd, d[k]);
      end
      repeat (B) @(negedge clk);
      chk("stop_bit", bus.txd, 1);
      wait_idle("single", 200);
      cmp_frames("single", 1);

      // Running status on
      do_reset();
      bus.running_status_en = 1'b1;
      stim = {8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
      send_stream(stim, 2);
      wait_idle("rs_on", 2000);
      cmp_frames("rs_on", 5);

      // SysEx clears running status
      do_reset();
      stim = {8'h90, 8'h3C, 8'h64, 8'hF0, 8'hF7, 8'h90};
      send_stream(stim, 0);
      wait_idle("rs_sysex", 2000);
      cmp_frames("rs_sysex", 6);

      // Realtime keeps running status
      do_reset();
      stim = {8'h90, 8'hF8, 8'h90};
      send_stream(stim, 1);
      wait_idle("rs_rt", 2000);
      cmp_frames("rs_rt", 2);

      // Running status off
      do_reset();
      bus.running_status_en = 1'b0;
      stim = {8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
      send_stream(stim, 0);
      wait_idle("rs_off", 2000);
      cmp_frames("rs_off", 6);

      // Overflow: back-to-back writes, first byte is popped early
      do_reset();
      for (int i = 1; i <= DEPTH + 2; i++) begin
         d = 8'($urandom_range(0, 127));
         @(negedge clk);
         bus.tx_data = d;
         bus.tx_write = 1'b1;
         if (i <= DEPTH + 1) model_push(d);
         @(posedge clk);
         #1;
         chk($sformatf("ovf_lvl%0d", i), bus.fifo_level, (i == 1) ? 1 : ((i - 1 > DEPTH) ? DEPTH : i - 1));
         chk($sformatf("ovf_full%0d", i), bus.tx_full, (i >= DEPTH + 1) ? 1 : 0);
         chk($sformatf("ovf_flag%0d", i), bus.overflow, (i >= DEPTH + 2) ? 1 : 0);
      end
      @(negedge clk);
      bus.tx_write = 1'b0;
      wait_idle("ovf", 3000);
      chk("ovf_sticky", bus.overflow, 1);
      cmp_frames("ovf", DEPTH + 1);

      // Randomized streams against the model
      do_reset();
      for (int r = 0; r < 6; r++) begin
         bus.running_status_en = 1'($urandom_range(0, 1));
         stim.delete();
         repeat ($urandom_range(4, 14)) stim.push_back(rnd_byte());
         send_stream(stim, 3);
         wait_idle($sformatf("rnd%0d", r), 3000);
         cmp_frames($sformatf("rnd%0d", r), -1);
      end

      // Reset during data bit 4
      do_reset();
      bus.running_status_en = 1'b0;
      @(negedge clk);
      bus.tx_data = 8'h55;
      bus.tx_write = 1'b1;
      @(negedge clk);
      bus.tx_data = 8'hAA;
      @(negedge clk);
      bus.tx_write = 1'b0;
      repeat (1 + 5 * B + B / 2) @(negedge clk);
      chk("mid_bit4", bus.txd, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_txd", bus.txd, 1);
      chk("mid_rst_lvl", bus.fifo_level, 0);
      chk("mid_rst_idle", bus.tx_idle, 1);
      reset = 1'b0;
      lows = 0;
      repeat (24 * B) begin
         @(negedge clk);
         if (bus.txd !== 1'b1) lows++;
      end
      chk("mid_no_low", lows, 0);
      chk("mid_no_frames", rx_q.size(), 0);
      chk("rx_framing", rx_ferr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
